paramest_mul_pipe: RTL and testbench
====================================

// Module: paramest_mul_pipe
// PURPOSE
//  Parametrised, pipelined fixed-point multiplier with valid/ready flow control for the ParamEst NN datapath.
//  Successor to the combinational HLS multiplier cores:
//  - per-operand signedness
//  - configurable latency with stall/backpressure
//  - post-multiply right shift with rounding
//  - wrap or saturate narrowing, with an overflow flag
//  Sits between layer accumulators and the weight ROM readout.
// PARAMETERS
//  DIN0_WIDTH  16  width of operand 0
//  DIN1_WIDTH  7   width of operand 1
//  DOUT_WIDTH  22  width of result
//  SIGNED0     0   1: din0 is two's complement
//  SIGNED1     0   1: din1 is two's complement
//  SHIFT       0   result right-shift (fraction drop), 0..DIN0_WIDTH+DIN1_WIDTH-1
//  SAT         0   0: wrap to DOUT_WIDTH; 1: clamp to DOUT range
//  NUM_STAGE   3   register stages input->output, >=1
// PORTS
//  ap_clk     in   1           clock, rising edge
//  ap_rst_n   in   1           asynchronous active-low reset
//  in_valid   in   1           operands valid
//  in_ready   out  1           block accepts operands this cycle
//  din0       in   DIN0_WIDTH  operand 0
//  din1       in   DIN1_WIDTH  operand 1
//  out_valid  out  1           result valid
//  out_ready  in   1           downstream accepts result
//  dout       out  DOUT_WIDTH  rounded/narrowed product
//  out_ovf    out  1           product did not fit DOUT_WIDTH (sideband to dout)
// BEHAVIOUR
//  - Reset, async assert, sync release: all stage valids=0, dout=0, out_ovf=0, out_valid=0.
//    in_ready=1 from the first cycle after release.
//  - Arithmetic:
//    - Full product P = ext(din0)*ext(din1), width DIN0_WIDTH+DIN1_WIDTH+1, signed internally.
//      ext = sign-extend if SIGNEDx else zero-extend.
//    - SHIFT>0: R = (P + 2^(SHIFT-1)) >>> SHIFT (round half toward +inf). SHIFT=0: R = P.
//    - Output range:
//      - signed if SIGNED0|SIGNED1: [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]
//      - else unsigned: [0, 2^DOUT_WIDTH-1]
//    - out_ovf = R outside the output range. Flagged for both SAT settings.
//    - SAT=0: dout = R[DOUT_WIDTH-1:0]. SAT=1: dout = R clamped to range.
//  - Pipeline (elastic):
//    - Stage k advances when it is empty or stage k+1 empty/advancing.
//    - Last stage advances on out_ready.
//    - in_ready = stage-1 can load (combinational on valids and out_ready; never on in_valid).
//    - Transfer on valid&ready at either side.
//  - Latency and throughput: with out_ready=1, result appears NUM_STAGE cycles after acceptance.
//    Throughput is 1 per cycle.
//  - Bubbles collapse: an empty stage accepts while later stages are stalled.
//  - Stall: while out_valid & !out_ready, dout/out_ovf are held stable. No item is dropped, duplicated or reordered.
//  - Full: all NUM_STAGE stages valid and out_ready=0 -> in_ready=0. in_ready rises in the same cycle out_ready rises.
//  - in_valid with in_ready=0: operands ignored; the source holds them.
//  - Reset mid-operation: all in-flight items are discarded; none emerge after release.
//  - Data registers need no reset (except dout/out_ovf). The multiply/round/sat may be retimed anywhere in the chain.
//    Only latency and results are observable.
// STRUCTURE
//  - Package paramest_mul_pkg:
//    - function mul_round_sat (ext, multiply, round, narrow, ovf), shared with other datapath cores
//    - typedef for stage {valid, data, ovf}
//    - localparams PROD_W, the output range bounds, and NUM_STAGE>=1 check
//  - Sub-module paramest_pipe_slice: one elastic valid/ready register slice (width param).
//    Instantiated NUM_STAGE times via generate.
// TESTING
//  1. Defaults, din0=16'hFFFF, din1=7'h7F -> P=8322945; dout=22'd4128641, out_ovf=1 (wrap).
//  2. Same operands, SAT=1 -> dout=22'h3FFFFF, out_ovf=1.
//  3. SIGNED0=SIGNED1=1, SHIFT=2: din0=-3, din1=5 -> -15 -> dout=-4 (22'h3FFFFC), out_ovf=0.
//     Also din0=-32768, din1=-64, SAT=1 -> 2^21 -> 22'h1FFFFF, out_ovf=1.
//  4. Single item at cycle 0, out_ready=1 -> out_valid exactly at cycle NUM_STAGE (check NUM_STAGE=1,3,5).
//     Then 100 back-to-back items -> 100 results, 1/cycle.
//  5. 8 items back-to-back, out_ready=0 cycles 4..9:
//     - in_ready=0 once NUM_STAGE items are held
//     - dout stable while stalled
//     - all 8 results in order; scoreboard vs reference model
//  6. ap_rst_n low for 1 cycle with 2 items in flight -> out_valid=0 immediately; no result after release.
//     Next item has normal latency.

Source files
------------

// File: rtl/paramest_mul_pkg.sv
// Shared arithmetic for the ParamEst fixed-point datapath cores: extend, multiply,
// round-half-up right shift, and wrap/saturate narrowing with an overflow flag.
package paramest_mul_pkg;

  localparam int MAX_W      = 64;
  localparam int IDX_W      = $clog2(MAX_W);
  // Headroom so the full product plus the rounding increment never overflows a longint.
  localparam int MAX_PROD_W = 62;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] val;
  } mrs_t;

  function automatic int prod_w(input int w0, input int w1);
    return w0 + w1 + 1;
  endfunction

  function automatic bit params_ok(input int w0, input int w1, input int wo,
                                   input int shift, input int nstage);
    return (nstage >= 1) && (w0 >= 1) && (w1 >= 1) && (wo >= 1) &&
           (prod_w(w0, w1) <= MAX_PROD_W) && (wo <= MAX_PROD_W) &&
           (shift >= 0) && (shift <= w0 + w1 - 1);
  endfunction

  function automatic longint out_lo(input int wo, input bit sgn);
    return sgn ? -(longint'(1) << (wo - 1)) : 64'sd0;
  endfunction

  function automatic longint out_hi(input int wo, input bit sgn);
    return sgn ? (longint'(1) << (wo - 1)) - 64'sd1 : (longint'(1) << wo) - 64'sd1;
  endfunction

  function automatic longint ext_op(input logic [MAX_W-1:0] v, input int w, input bit sgn);
    longint r;
    r = longint'(v & ((64'd1 << w) - 64'd1));
    if (sgn && v[IDX_W'(w - 1)]) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic mrs_t mul_round_sat(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input int               wa,
    input int               wb,
    input int               wo,
    input bit               sa,
    input bit               sb,
    input int               shift,
    input bit               sat
  );
    longint p, r, lo, hi;
    mrs_t   res;
    p = ext_op(a, wa, sa) * ext_op(b, wb, sb);
    r = p;
    if (shift > 0) r = (p + (longint'(1) << (shift - 1))) >>> shift;
    lo      = out_lo(wo, sa | sb);
    hi      = out_hi(wo, sa | sb);
    res.ovf = (r < lo) || (r > hi);
    if (sat && (r < lo)) r = lo;
    else if (sat && (r > hi)) r = hi;
    res.val = r;
    return res;
  endfunction

endpackage

// File: rtl/paramest_mul_if.sv
// Operand/result handshake bundle of the ParamEst multiplier; slave is the multiplier side.
interface paramest_mul_if #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 7,
  parameter int DOUT_WIDTH = 22
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic                  out_ready;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  out_ovf;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, out_ovf
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, out_ovf
  );
endinterface

// File: rtl/paramest_pipe_slice.sv
// One elastic register slice: loads when the chain says this stage may advance,
// otherwise holds its item (or its bubble).
module paramest_pipe_slice #(
  parameter int WIDTH      = 8,
  parameter bit RESET_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data
);
  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (up_ready) begin
      valid_d = up_valid;
      if (up_valid) data_d = up_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  if (RESET_DATA) begin : g_data_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
    end
  end else begin : g_data_nrst
    always_ff @(posedge clk) data_q <= data_d;
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;
endmodule

// File: rtl/paramest_mul_pipe.sv
// Pipelined fixed-point multiplier: arithmetic is done ahead of the first slice and the
// result rides NUM_STAGE elastic slices, so latency is exactly NUM_STAGE at full rate.
module paramest_mul_pipe
  import paramest_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 7,
  parameter int DOUT_WIDTH = 22,
  parameter int SIGNED0    = 0,
  parameter int SIGNED1    = 0,
  parameter int SHIFT      = 0,
  parameter int SAT        = 0,
  parameter int NUM_STAGE  = 3
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  paramest_mul_if.slave   io
);
  localparam int PROD_W    = prod_w(DIN0_WIDTH, DIN1_WIDTH);
  localparam int PAY_W     = DOUT_WIDTH + 1;
  localparam bit PARAMS_OK = params_ok(DIN0_WIDTH, DIN1_WIDTH, DOUT_WIDTH, SHIFT, NUM_STAGE)
                             && (PROD_W <= MAX_PROD_W);

  if (!PARAMS_OK) begin : g_bad_param
    $error("paramest_mul_pipe: illegal parameter combination");
  end

  typedef struct packed {
    logic                  valid;
    logic                  ovf;
    logic [DOUT_WIDTH-1:0] data;
  } stage_t;

  mrs_t                          mrs;
  stage_t                        s_in, s_out;
  logic [NUM_STAGE:0]            vld_pipe;
  logic [NUM_STAGE:0]            rdy;
  logic [NUM_STAGE:0][PAY_W-1:0] pay_pipe;

  always_comb begin
    mrs        = mul_round_sat(MAX_W'(io.din0), MAX_W'(io.din1),
                               DIN0_WIDTH, DIN1_WIDTH, DOUT_WIDTH,
                               SIGNED0 != 0, SIGNED1 != 0, SHIFT, SAT != 0);
    s_in.valid = io.in_valid;
    s_in.ovf   = mrs.ovf;
    s_in.data  = DOUT_WIDTH'(mrs.val);
  end

  // Stage k may load if it is empty or any later stage is empty, or the output drains;
  // derived from registered valids only, so ready never depends on in_valid.
  always_comb begin
    rdy            = '0;
    rdy[NUM_STAGE] = io.out_ready;
    for (int k = NUM_STAGE - 1; k >= 0; k--) rdy[k] = rdy[k+1] | ~vld_pipe[k+1];
  end

  assign vld_pipe[0] = s_in.valid;
  assign pay_pipe[0] = {s_in.ovf, s_in.data};

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
    paramest_pipe_slice #(
      .WIDTH      (PAY_W),
      .RESET_DATA (k == NUM_STAGE - 1)
    ) u_slice (
      .clk      (ap_clk),
      .rst_n    (ap_rst_n),
      .up_valid (vld_pipe[k]),
      .up_ready (rdy[k]),
      .up_data  (pay_pipe[k]),
      .dn_valid (vld_pipe[k+1]),
      .dn_data  (pay_pipe[k+1])
    );
  end

  always_comb begin
    s_out.valid             = vld_pipe[NUM_STAGE];
    {s_out.ovf, s_out.data} = pay_pipe[NUM_STAGE];
  end

  assign io.in_ready  = rdy[0];
  assign io.out_valid = s_out.valid;
  assign io.dout      = s_out.data;
  assign io.out_ovf   = s_out.ovf;
endmodule

// File: tb/tb_paramest_mul_pipe.sv
// Four multiplier configurations share one operand stream; each is scored against an
// arithmetic reference model, with latency, stall and reset behaviour checked directly.
module tb_paramest_mul_pipe;
  localparam int NG = 4;
  localparam int W0 = 16;
  localparam int W1 = 7;
  localparam int WO = 22;
  localparam int CFG_S0  [NG] = '{0, 0, 1, 1};
  localparam int CFG_S1  [NG] = '{0, 0, 1, 1};
  localparam int CFG_SH  [NG] = '{0, 0, 2, 0};
  localparam int CFG_SAT [NG] = '{0, 1, 0, 1};
  localparam int CFG_NS  [NG] = '{3, 3, 1, 5};

  typedef struct packed {
    logic          ovf;
    logic [WO-1:0] d;
  } res_t;

  logic          ap_clk    = 1'b0;
  logic          ap_rst_n  = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b1;
  logic [W0-1:0] din0      = '0;
  logic [W1-1:0] din1      = '0;
  logic          ovalid [NG];
  logic          iready [NG];
  logic          ovf    [NG];
  logic [WO-1:0] dout   [NG];

  always #5 ap_clk = ~ap_clk;

  for (genvar g = 0; g < NG; g++) begin : g_dut
    paramest_mul_if #(.DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(WO)) ifc ();
    assign ifc.in_valid  = in_valid;
    assign ifc.din0      = din0;
    assign ifc.din1      = din1;
    assign ifc.out_ready = (g == 0) ? out_ready : 1'b1;
    assign ovalid[g]     = ifc.out_valid;
    assign iready[g]     = ifc.in_ready;
    assign ovf[g]        = ifc.out_ovf;
    assign dout[g]       = ifc.dout;

    paramest_mul_pipe #(
      .DIN0_WIDTH (W0), .DIN1_WIDTH (W1), .DOUT_WIDTH (WO),
      .SIGNED0 (CFG_S0[g]), .SIGNED1 (CFG_S1[g]), .SHIFT (CFG_SH[g]),
      .SAT (CFG_SAT[g]), .NUM_STAGE (CFG_NS[g])
    ) u_dut (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .io       (ifc)
    );
  end

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc_no = 0;
  int   first_ov [NG];
  int   last_oc  [NG];
  int   out_cnt  [NG];
  res_t last_res [NG];
  res_t exq      [NG][$];
  bit   stall_prev = 1'b0;
  res_t held;
  bit   acc0 = 1'b0;
  bit   ir0  = 1'b0;

  // Reference: exact integer product, floor((P + half) / 2^SHIFT), then range test.
  function automatic res_t model(input int g, input logic [W0-1:0] a, input logic [W1-1:0] b);
    longint va, vb, p, den, num, q, lo, hi, m;
    res_t   r;
    va = longint'(a);
    vb = longint'(b);
    if (CFG_S0[g] != 0 && a[W0-1]) va = va - (longint'(1) << W0);
    if (CFG_S1[g] != 0 && b[W1-1]) vb = vb - (longint'(1) << W1);
    p   = va * vb;
    den = longint'(1) << CFG_SH[g];
    num = p + den / 2;
    q   = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    if ((CFG_S0[g] | CFG_S1[g]) != 0) begin
      lo = -(longint'(1) << (WO - 1));
      hi = (longint'(1) << (WO - 1)) - 1;
    end else begin
      lo = 0;
      hi = (longint'(1) << WO) - 1;
    end
    r.ovf = (q < lo) || (q > hi);
    m = q;
    if (CFG_SAT[g] != 0) m = (q < lo) ? lo : ((q > hi) ? hi : q);
    r.d = WO'(m);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    cyc_no = 0;
    for (int g = 0; g < NG; g++) begin
      first_ov[g] = -1;
      last_oc[g]  = -1;
      out_cnt[g]  = 0;
    end
  endtask

  // Samples one cycle just after the falling edge, scores it, then waits for the next one.
  task automatic cyc();
    res_t e;
    bit   ordy;
    #1;
    for (int g = 0; g < NG; g++) begin
      ordy = (g == 0) ? out_ready : 1'b1;
      if (ap_rst_n) begin
        chk($sformatf("in_ready[%0d]@%0d", g, cyc_no), 64'(iready[g]),
            64'(ordy || (exq[g].size() < CFG_NS[g])));
        if (g == 0 && stall_prev)
          chk($sformatf("stall_hold@%0d", cyc_no), 64'({ovalid[0], ovf[0], dout[0]}),
              64'({1'b1, held}));
        if (ovalid[g] && ordy) begin
          if (exq[g].size() == 0) begin
            chk($sformatf("spurious_out[%0d]@%0d", g, cyc_no), 64'(ovalid[g]), 64'(1'b0));
          end else begin
            e = exq[g].pop_front();
            chk($sformatf("result[%0d]@%0d", g, cyc_no), 64'({ovf[g], dout[g]}), 64'(e));
          end
          last_res[g] = {ovf[g], dout[g]};
          out_cnt[g]++;
          last_oc[g] = cyc_no;
          if (first_ov[g] < 0) first_ov[g] = cyc_no;
        end
        if (in_valid && iready[g]) exq[g].push_back(model(g, din0, din1));
      end
    end
    acc0       = in_valid && iready[0] && ap_rst_n;
    ir0        = iready[0];
    stall_prev = ovalid[0] && !out_ready && ap_rst_n;
    held       = {ovf[0], dout[0]};
    cyc_no++;
    @(negedge ap_clk);
  endtask

  logic [W0-1:0] t5_a [8];
  logic [W1-1:0] t5_b [8];
  int            idx;

  initial begin
    mark();
    repeat (2) @(negedge ap_clk);
    #1;
    for (int g = 0; g < NG; g++) begin
      chk($sformatf("rst_out_valid[%0d]", g), 64'(ovalid[g]), 64'(1'b0));
      chk($sformatf("rst_dout[%0d]", g), 64'({ovf[g], dout[g]}), 64'(0));
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Single item, full-scale unsigned operands: latency per depth, wrap and saturate.
    mark();
    in_valid = 1'b1; din0 = 16'hFFFF; din1 = 7'h7F;
    cyc();
    chk("in_ready_after_release", 64'(ir0), 64'(1'b1));
    in_valid = 1'b0;
    repeat (8) cyc();
    for (int g = 0; g < NG; g++)
      chk($sformatf("latency[%0d]", g), 64'(first_ov[g]), 64'(CFG_NS[g]));
    chk("wrap_dout", 64'(last_res[0]), 64'({1'b1, 22'd4128641}));
    chk("sat_dout", 64'(last_res[1]), 64'({1'b1, 22'h3FFFFF}));

    // Signed, rounded: -3 * 5 = -15 -> -4 after rounding shift by 2.
    in_valid = 1'b1; din0 = 16'hFFFD; din1 = 7'h05;
    cyc();
    in_valid = 1'b0;
    repeat (8) cyc();
    chk("signed_round", 64'(last_res[2]), 64'({1'b0, 22'h3FFFFC}));

    // Signed, no shift: -32768 * -64 = 2^21 clamps to the positive limit.
    in_valid = 1'b1; din0 = 16'h8000; din1 = 7'h40;
    cyc();
    in_valid = 1'b0;
    repeat (8) cyc();
    chk("signed_sat", 64'(last_res[3]), 64'({1'b1, 22'h1FFFFF}));

    // 100 back-to-back items at full rate.
    mark();
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; din0 = W0'($urandom); din1 = W1'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    repeat (8) cyc();
    for (int g = 0; g < NG; g++) begin
      chk($sformatf("burst_count[%0d]", g), 64'(out_cnt[g]), 64'(100));
      chk($sformatf("burst_span[%0d]", g), 64'(last_oc[g] - first_ov[g]), 64'(99));
    end

    // 8 items with the sink stalled on cycles 4..9.
    for (int i = 0; i < 8; i++) begin
      t5_a[i] = W0'($urandom);
      t5_b[i] = W1'($urandom);
    end
    mark();
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 4 && c <= 9);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        din0 = t5_a[idx];
        din1 = t5_b[idx];
      end
      cyc();
      if (c >= 4 && c <= 9) chk($sformatf("full_in_ready@%0d", c), 64'(ir0), 64'(1'b0));
      if (c == 10) chk("in_ready_rises_with_out_ready", 64'(ir0), 64'(1'b1));
      if (acc0) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stall_all_results", 64'(out_cnt[0]), 64'(8));

    // Reset with two items in flight: nothing emerges afterwards.
    in_valid = 1'b1; din0 = W0'($urandom); din1 = W1'($urandom);
    cyc();
    din0 = W0'($urandom); din1 = W1'($urandom);
    cyc();
    in_valid = 1'b0;
    ap_rst_n = 1'b0;
    #1;
    for (int g = 0; g < NG; g++) begin
      chk($sformatf("midrst_out_valid[%0d]", g), 64'(ovalid[g]), 64'(1'b0));
      exq[g].delete();
    end
    stall_prev = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    mark();
    repeat (8) cyc();
    for (int g = 0; g < NG; g++)
      chk($sformatf("no_ghost[%0d]", g), 64'(out_cnt[g]), 64'(0));
    mark();
    in_valid = 1'b1; din0 = W0'($urandom); din1 = W1'($urandom);
    cyc();
    in_valid = 1'b0;
    repeat (8) cyc();
    for (int g = 0; g < NG; g++)
      chk($sformatf("post_rst_latency[%0d]", g), 64'(first_ov[g]), 64'(CFG_NS[g]));

    // Random valid/ready traffic; the source holds operands until the stallable unit takes them.
    acc0 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!in_valid || acc0) begin
        in_valid = ($urandom_range(0, 9) < 7);
        din0     = W0'($urandom);
        din1     = W1'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 6);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) cyc();
    for (int g = 0; g < NG; g++)
      chk($sformatf("drained[%0d]", g), 64'(exq[g].size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
